// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes codec BCLK/ADCLRCK/ADCDAT into clk and emits left/right sample pairs
// over a valid/ready handshake. Optional overrun detection is enabled by I2S_RX_OVERRUN_EN.
module i2s_receiver #(
   parameter int unsigned LEADING_BITS  = 1,
   parameter int unsigned DATA_BITS     = 16,
   parameter int unsigned TRAILING_BITS = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 codec_aud_bclk_i,
   input  logic                 codec_aud_adclrck_i,
   input  logic                 codec_aud_adcdat_i,
   input  logic                 i2s_en_i,
   output logic [DATA_BITS-1:0] i2s_sample_data_L_o,
   output logic [DATA_BITS-1:0] i2s_sample_data_R_o,
   output logic                 i2s_valid_o,
   input  logic                 i2s_ready_i,
   output logic                 i2s_overrun_o
);

   localparam int unsigned CntW = $clog2(LEADING_BITS + DATA_BITS + TRAILING_BITS + 1);
   localparam logic [CntW-1:0] CntMax    = '1;
   localparam logic [CntW-1:0] DataFirst = CntW'(LEADING_BITS);
   localparam logic [CntW-1:0] DataEnd   = CntW'(LEADING_BITS + DATA_BITS);

   typedef enum logic [1:0] {StIdle, StSync, StRight, StLeft} state_e;

   state_e               state_q, state_d;
   logic                 bclk_s1_q, bclk_s2_q, bclk_h_q;
   logic                 lrck_s1_q, lrck_s2_q, lrck_h_q;
   logic                 dat_s1_q, dat_s2_q;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DATA_BITS-1:0] sr_l_q, sr_l_d, sr_r_q, sr_r_d;
   logic [DATA_BITS-1:0] r_hold_q, r_hold_d;
   logic                 r_ok_q, r_ok_d;
   logic [DATA_BITS-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
   logic                 valid_q, valid_d;

   logic bclk_rise, lrck_edge, lrck_rise, lrck_fall;
   logic in_window, half_done, bit_take, new_pair, accept;

   assign bclk_rise = bclk_s2_q & ~bclk_h_q;
   assign lrck_edge = lrck_s2_q ^ lrck_h_q;
   assign lrck_rise = lrck_s2_q & ~lrck_h_q;
   assign lrck_fall = ~lrck_s2_q & lrck_h_q;
   assign in_window = (cnt_q >= DataFirst) && (cnt_q < DataEnd);
   assign half_done = cnt_q >= DataEnd;
   // An LRCK edge in the same cycle as a BCLK edge belongs to the new half; the bit is dropped.
   assign bit_take  = bclk_rise & ~lrck_edge & in_window;
   assign new_pair  = i2s_en_i && (state_q == StLeft) && lrck_fall && r_ok_q && half_done;
   assign accept    = valid_q & i2s_ready_i;

   always_comb begin
      state_d = state_q;
      if (!i2s_en_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StSync;
            StSync:  if (lrck_fall) state_d = StRight;
            StRight: if (lrck_rise) state_d = StLeft;
            StLeft:  if (lrck_fall) state_d = StRight;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      sr_l_d   = sr_l_q;
      sr_r_d   = sr_r_q;
      r_hold_d = r_hold_q;
      r_ok_d   = r_ok_q;
      if (lrck_edge) begin
         cnt_d = '0;
      end else if (bclk_rise && cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (bit_take && state_q == StRight) sr_r_d = {sr_r_q[DATA_BITS-2:0], dat_s2_q};
      if (bit_take && state_q == StLeft)  sr_l_d = {sr_l_q[DATA_BITS-2:0], dat_s2_q};
      if (i2s_en_i && state_q == StRight && lrck_rise) begin
         r_ok_d = half_done;
         if (half_done) r_hold_d = sr_r_q;
      end
   end

`ifdef I2S_RX_OVERRUN_EN
   logic overrun_q, overrun_d;

   always_comb begin
      data_l_d  = data_l_q;
      data_r_d  = data_r_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (new_pair && valid_q && !i2s_ready_i) begin
         overrun_d = 1'b1;
      end else if (new_pair) begin
         data_l_d = sr_l_q;
         data_r_d = r_hold_q;
         valid_d  = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end
      if (!i2s_en_i) overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) overrun_q <= 1'b0;
      else        overrun_q <= overrun_d;
   end

   assign i2s_overrun_o = overrun_q;
`else
   always_comb begin
      data_l_d = data_l_q;
      data_r_d = data_r_q;
      valid_d  = valid_q;
      if (new_pair) begin
         data_l_d = sr_l_q;
         data_r_d = r_hold_q;
         valid_d  = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   assign i2s_overrun_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bclk_s1_q <= 1'b0;
         bclk_s2_q <= 1'b0;
         bclk_h_q  <= 1'b0;
         lrck_s1_q <= 1'b0;
         lrck_s2_q <= 1'b0;
         lrck_h_q  <= 1'b0;
         dat_s1_q  <= 1'b0;
         dat_s2_q  <= 1'b0;
         cnt_q     <= '0;
         sr_l_q    <= '0;
         sr_r_q    <= '0;
         r_hold_q  <= '0;
         r_ok_q    <= 1'b0;
         data_l_q  <= '0;
         data_r_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bclk_s1_q <= codec_aud_bclk_i;
         bclk_s2_q <= bclk_s1_q;
         bclk_h_q  <= bclk_s2_q;
         lrck_s1_q <= codec_aud_adclrck_i;
         lrck_s2_q <= lrck_s1_q;
         lrck_h_q  <= lrck_s2_q;
         dat_s1_q  <= codec_aud_adcdat_i;
         dat_s2_q  <= dat_s1_q;
         cnt_q     <= cnt_d;
         sr_l_q    <= sr_l_d;
         sr_r_q    <= sr_r_d;
         r_hold_q  <= r_hold_d;
         r_ok_q    <= r_ok_d;
         data_l_q  <= data_l_d;
         data_r_q  <= data_r_d;
         valid_q   <= valid_d;
      end
   end

   assign i2s_sample_data_L_o = data_l_q;
   assign i2s_sample_data_R_o = data_r_q;
   assign i2s_valid_o         = valid_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives codec half-frames bit by bit and scoreboards accepted pairs
// against expectations derived from frame lengths and data.
module tb_i2s_receiver;

   localparam int L = 1;
   localparam int D = 16;
   localparam int T = 15;
   localparam int Full = L + D + T;

   logic        clk, rst_n;
   logic        bclk, lrck, dat, en, ready;
   logic [15:0] data_l, data_r;
   logic        valid, ovr;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] got_q[$];
   bit          pend_has;
   logic [15:0] pend_l, pend_r;

   typedef struct {
      logic [15:0] r;
      logic [15:0] l;
      int          rb;
      int          lb;
      bit          has;
   } vec_t;
   vec_t tbl[6];

   i2s_receiver #(
      .LEADING_BITS (L),
      .DATA_BITS    (D),
      .TRAILING_BITS(T)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .codec_aud_bclk_i   (bclk),
      .codec_aud_adclrck_i(lrck),
      .codec_aud_adcdat_i (dat),
      .i2s_en_i           (en),
      .i2s_sample_data_L_o(data_l),
      .i2s_sample_data_R_o(data_r),
      .i2s_valid_o        (valid),
      .i2s_ready_i        (ready),
      .i2s_overrun_o      (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every handshake the consumer side completes.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) got_q.push_back({data_l, data_r});
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_got(input string name, input bit has, input logic [15:0] el,
                            input logic [15:0] er);
      chk({name, "_count"}, 32'(got_q.size()), {31'd0, has});
      if (has && got_q.size() > 0) chk({name, "_data"}, got_q[0], {el, er});
      got_q.delete();
   endtask

   // One LRCK half: nbits BCLK periods, data placed after the leading bits, MSB first.
   // rdy_at >= 0 drives ready high only during step rdy_at of this half.
   task automatic send_half(input bit lr, input logic [15:0] data, input int nbits,
                            input int rdy_at);
      int k = 0;
      for (int i = 0; i < nbits; i++) begin
         if (i == 0) lrck = lr;
         bclk = 1'b0;
         if (i >= L && i < L + D) dat = data[D-1-(i-L)];
         else                     dat = 1'($urandom_range(0, 1));
         for (int s = 0; s < 8; s++) begin
            if (s == 4) bclk = 1'b1;
            if (rdy_at >= 0) ready = (k == rdy_at);
            step();
            k++;
         end
      end
   endtask

   task automatic run_frame(input string name, input logic [15:0] r, input logic [15:0] l,
                            input int rb, input int lb, input bit has);
      send_half(1'b0, r, rb, -1);
      check_got(name, pend_has, pend_l, pend_r);
      send_half(1'b1, l, lb, -1);
      pend_has = has;
      pend_l   = l;
      pend_r   = r;
   endtask

   initial begin
      logic [15:0] rr, ll;
      int          rb, lb;

      tbl[0] = '{r: 16'h1234, l: 16'hA5C3, rb: Full,  lb: Full,  has: 1'b1};
      tbl[1] = '{r: 16'h0F0F, l: 16'hF0F0, rb: Full,  lb: L + 8, has: 1'b0};
      tbl[2] = '{r: 16'hFFFF, l: 16'h0001, rb: Full,  lb: Full,  has: 1'b1};
      tbl[3] = '{r: 16'h5A5A, l: 16'h6B6B, rb: L + 15, lb: Full, has: 1'b0};
      tbl[4] = '{r: 16'hC001, l: 16'h3FFE, rb: L + D, lb: L + D, has: 1'b1};
      tbl[5] = '{r: 16'h8000, l: 16'h7FFF, rb: Full,  lb: Full,  has: 1'b1};

      rst_n = 1'b0; en = 1'b0; ready = 1'b1; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
      pend_has = 1'b0; pend_l = '0; pend_r = '0;
      repeat (4) step();
      rst_n = 1'b1;
      step();
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_L", {16'd0, data_l}, 32'd0);
      chk("reset_R", {16'd0, data_r}, 32'd0);
      chk("reset_overrun", {31'd0, ovr}, 32'd0);

      // Enable in the middle of a left half: that partial frame must yield nothing.
      send_half(1'b1, 16'hBEEF, 10, -1);
      en = 1'b1;
      send_half(1'b1, 16'hBEEF, 22, -1);
      pend_has = 1'b0;

      foreach (tbl[i]) run_frame($sformatf("tbl%0d", i), tbl[i].r, tbl[i].l, tbl[i].rb,
                                 tbl[i].lb, tbl[i].has);

      for (int n = 0; n < 16; n++) begin
         rr = 16'($urandom);
         ll = 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, L + D - 1) : $urandom_range(L + D, Full);
         lb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, L + D - 1) : $urandom_range(L + D, Full);
         run_frame($sformatf("rnd%0d", n), rr, ll, rb, lb, (rb >= L + D) && (lb >= L + D));
      end

      // Two pairs with ready held low.
      send_half(1'b0, 16'h1111, Full, -1);
      check_got("rnd_last", pend_has, pend_l, pend_r);
      ready = 1'b0;
      send_half(1'b1, 16'h2222, Full, -1);
      send_half(1'b0, 16'h3333, Full, -1);
      send_half(1'b1, 16'h4444, Full, -1);
      send_half(1'b0, 16'h5555, Full, -1);
      chk("ovr_valid", {31'd0, valid}, 32'd1);
`ifdef I2S_RX_OVERRUN_EN
      chk("ovr_L", {16'd0, data_l}, 32'h2222);
      chk("ovr_R", {16'd0, data_r}, 32'h1111);
      chk("ovr_flag", {31'd0, ovr}, 32'd1);
      ll = 16'h2222; rr = 16'h1111;
`else
      chk("ovr_L", {16'd0, data_l}, 32'h4444);
      chk("ovr_R", {16'd0, data_r}, 32'h3333);
      chk("ovr_flag", {31'd0, ovr}, 32'd0);
      ll = 16'h4444; rr = 16'h3333;
`endif
      en = 1'b0;
      step(); step();
      chk("dis_overrun", {31'd0, ovr}, 32'd0);
      chk("dis_valid", {31'd0, valid}, 32'd1);
      chk("dis_L", {16'd0, data_l}, {16'd0, ll});
      chk("dis_R", {16'd0, data_r}, {16'd0, rr});
      ready = 1'b1;
      step(); step();
      chk("dis_accept_valid", {31'd0, valid}, 32'd0);
      check_got("dis_accept", 1'b1, ll, rr);

      // Acceptance coinciding with a new pair.
      en = 1'b1;
      ready = 1'b0;
      send_half(1'b1, 16'h0000, Full, -1);
      send_half(1'b0, 16'hAAAA, Full, -1);
      send_half(1'b1, 16'hBBBB, Full, -1);
      send_half(1'b0, 16'hCCCC, Full, -1);
      send_half(1'b1, 16'hDDDD, Full, -1);
      send_half(1'b0, 16'hEEEE, Full, 2);
      check_got("same_cycle_accept", 1'b1, 16'hBBBB, 16'hAAAA);
      chk("same_cycle_valid", {31'd0, valid}, 32'd1);
      chk("same_cycle_L", {16'd0, data_l}, 32'hDDDD);
      chk("same_cycle_R", {16'd0, data_r}, 32'hCCCC);
      chk("same_cycle_overrun", {31'd0, ovr}, 32'd0);

      // Reset in the middle of a left half.
      send_half(1'b1, 16'hFFFF, 10, -1);
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_L", {16'd0, data_l}, 32'd0);
      chk("midrst_R", {16'd0, data_r}, 32'd0);
      chk("midrst_overrun", {31'd0, ovr}, 32'd0);
      send_half(1'b1, 16'hFFFF, 22, -1);
      ready = 1'b1;
      pend_has = 1'b0;
      run_frame("midrst_resync", 16'h0F1E, 16'h2D3C, Full, Full, 1'b1);
      send_half(1'b0, 16'h0000, Full, -1);
      check_got("midrst_pair", pend_has, pend_l, pend_r);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
